// File: rtl/weight_read_scheduler_if.sv
// -----------------------------------------------------------------------------
// weight_read_scheduler_if
// Bundles every non-clock/reset signal of the weight read scheduler.
//   Layer command : layer_start, load_weights, kernel_size, output_channel_size
//   BRAM control  : write_weight_finish, weight_from_bram_valid (in);
//                   transfer_start, write_en, bram_control_add1/add2, port_sel (out)
//   MAC handshake : weight_ready (in); weight_valid, cur_row, cur_oc (out)
//   Status        : layer_finish, busy (out)
// Modports:
//   master - the surrounding system (layer control, BRAM controller, MAC side)
//   slave  - the scheduler itself
// -----------------------------------------------------------------------------
interface weight_read_scheduler_if #(
  parameter int OC_WIDTH = 12,
  parameter int KS_WIDTH = 5
);
  logic                layer_start;
  logic                load_weights;
  logic [KS_WIDTH-1:0] kernel_size;
  logic [OC_WIDTH-1:0] output_channel_size;
  logic                write_weight_finish;
  logic                weight_from_bram_valid;
  logic                weight_ready;
  logic                transfer_start;
  logic                write_en;
  logic                bram_control_add1;
  logic                bram_control_add2;
  logic                port_sel;
  logic                weight_valid;
  logic [2:0]          cur_row;
  logic [OC_WIDTH-1:0] cur_oc;
  logic                layer_finish;
  logic                busy;

  modport master (
    output layer_start, load_weights, kernel_size, output_channel_size,
           write_weight_finish, weight_from_bram_valid, weight_ready,
    input  transfer_start, write_en, bram_control_add1, bram_control_add2,
           port_sel, weight_valid, cur_row, cur_oc, layer_finish, busy
  );

  modport slave (
    input  layer_start, load_weights, kernel_size, output_channel_size,
           write_weight_finish, weight_from_bram_valid, weight_ready,
    output transfer_start, write_en, bram_control_add1, bram_control_add2,
           port_sel, weight_valid, cur_row, cur_oc, layer_finish, busy
  );
endinterface

// File: rtl/weight_read_scheduler.sv
// -----------------------------------------------------------------------------
// weight_read_scheduler
// Layer-level sequencer for the weight BRAM controller. On a layer command it
// optionally runs the weight preload (BRAM written from the AXIS preload FIFO),
// then walks every weight row (kernel row x output channel) out of BRAM, one
// row per consumer valid/ready handshake.
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (aborts a layer, no finish pulse)
//   bus   - weight_read_scheduler_if.slave (command, BRAM control, MAC side)
//
// Optional feature (compile-time macro WSCHED_DUAL_READ_EN):
//   When defined, the row at address+1 is presented from BRAM port B
//   (S_RD_HOLD_B) right after a port-A row, and the address then advances by
//   two. When undefined, port_sel and bram_control_add2 are tied low.
//
// All outputs are registered and decoded from the next state, so they are
// aligned with the registered state and glitch-free.
// -----------------------------------------------------------------------------
module weight_read_scheduler #(
  parameter int OC_WIDTH = 12,
  parameter int KS_WIDTH = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  weight_read_scheduler_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LD_START  = 4'd1,
    S_LOAD      = 4'd2,
    S_LD_GAP    = 4'd3,
    S_RD_START  = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_RD_HOLD   = 4'd6,
    S_RD_ADV    = 4'd7,
    S_DONE      = 4'd8,
    S_RD_HOLD_B = 4'd9
  } state_t;

  // One-hot kernel_size to K; anything that is not a legal one-hot code is K=1.
  function automatic logic [2:0] decode_k(input logic [KS_WIDTH-1:0] ks);
    logic [2:0] k;
    case (ks)
      KS_WIDTH'(1):  k = 3'd1;
      KS_WIDTH'(2):  k = 3'd2;
      KS_WIDTH'(4):  k = 3'd3;
      KS_WIDTH'(8):  k = 3'd4;
      KS_WIDTH'(16): k = 3'd5;
      default:       k = 3'd1;
    endcase
    return k;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [OC_WIDTH-1:0] oc_size_q, oc_size_d;
  logic [2:0]          row_q, row_d;
  logic [OC_WIDTH-1:0] oc_q, oc_d;

  logic transfer_start_q, transfer_start_d;
  logic write_en_q, write_en_d;
  logic add1_q, add1_d;
  logic weight_valid_q, weight_valid_d;
  logic layer_finish_q, layer_finish_d;
  logic busy_q, busy_d;

  logic                row_wrap_s;
  logic                last_s;
  logic [2:0]          adv_row_s;
  logic [OC_WIDTH-1:0] adv_oc_s;

`ifdef WSCHED_DUAL_READ_EN
  localparam int CW = OC_WIDTH + 3;

  // total = K*OC held at OC_WIDTH+3 bits so it cannot overflow (K <= 5 < 8).
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] idx_q, idx_d;
  // Set when the coming S_RD_ADV must skip the row already shown on port B.
  logic          adv2_q, adv2_d;
  logic          add2_q, add2_d;
  logic          port_sel_q, port_sel_d;
  logic [CW-1:0] rows_left_s;
  logic          pair_ok_s;
`endif

  assign row_wrap_s = (row_q == (k_q - 3'd1));
  assign last_s     = row_wrap_s && (oc_q == (oc_size_q - OC_WIDTH'(1)));
  assign adv_row_s  = row_wrap_s ? 3'd0 : (row_q + 3'd1);
  assign adv_oc_s   = row_wrap_s ? (oc_q + OC_WIDTH'(1)) : oc_q;

`ifdef WSCHED_DUAL_READ_EN
  // Rows left including the current one; >= 3 means at least two follow it.
  assign rows_left_s = total_q - idx_q;
  assign pair_ok_s   = (rows_left_s >= CW'(3));
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    oc_size_d = oc_size_q;
    row_d     = row_q;
    oc_d      = oc_q;
`ifdef WSCHED_DUAL_READ_EN
    total_d   = total_q;
    idx_d     = idx_q;
    adv2_d    = adv2_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.layer_start) begin
          k_d       = decode_k(bus.kernel_size);
          oc_size_d = bus.output_channel_size;
          row_d     = 3'd0;
          oc_d      = '0;
`ifdef WSCHED_DUAL_READ_EN
          total_d   = CW'(decode_k(bus.kernel_size)) * CW'(bus.output_channel_size);
          idx_d     = '0;
          adv2_d    = 1'b0;
`endif
          if (bus.output_channel_size == '0) begin
            state_d = S_DONE;
          end else if (bus.load_weights) begin
            state_d = S_LD_START;
          end else begin
            state_d = S_RD_START;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_START: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.write_weight_finish) begin
          state_d = S_LD_GAP;
        end else begin
          state_d = S_LOAD;
        end
      end
      // One idle cycle so the BRAM write FSM is back in idle before the read.
      S_LD_GAP:   state_d = S_RD_START;
      S_RD_START: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.weight_from_bram_valid) begin
          state_d = S_RD_HOLD;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_HOLD: begin
        if (bus.weight_ready) begin
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            row_d = adv_row_s;
            oc_d  = adv_oc_s;
`ifdef WSCHED_DUAL_READ_EN
            idx_d = idx_q + CW'(1);
            if (pair_ok_s) begin
              state_d = S_RD_HOLD_B;
            end else begin
              adv2_d  = 1'b0;
              state_d = S_RD_ADV;
            end
`else
            state_d = S_RD_ADV;
`endif
          end
        end else begin
          state_d = S_RD_HOLD;
        end
      end
`ifdef WSCHED_DUAL_READ_EN
      S_RD_HOLD_B: begin
        if (bus.weight_ready) begin
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            row_d   = adv_row_s;
            oc_d    = adv_oc_s;
            idx_d   = idx_q + CW'(1);
            adv2_d  = 1'b1;
            state_d = S_RD_ADV;
          end
        end else begin
          state_d = S_RD_HOLD_B;
        end
      end
`endif
      // BRAM valid in this cycle still belongs to the old address: ignore it.
      S_RD_ADV: state_d = S_RD_WAIT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    transfer_start_d = (state_d == S_LD_START) || (state_d == S_RD_START);
    write_en_d       = (state_d == S_LD_START) || (state_d == S_LOAD);
    layer_finish_d   = (state_d == S_DONE);
    busy_d           = (state_d != S_IDLE);
`ifdef WSCHED_DUAL_READ_EN
    weight_valid_d   = (state_d == S_RD_HOLD) || (state_d == S_RD_HOLD_B);
    port_sel_d       = (state_d == S_RD_HOLD_B);
    add1_d           = (state_d == S_RD_ADV) && !adv2_d;
    add2_d           = (state_d == S_RD_ADV) && adv2_d;
`else
    weight_valid_d   = (state_d == S_RD_HOLD);
    add1_d           = (state_d == S_RD_ADV);
`endif
  end

  // State, latched layer configuration, row/channel counters and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      k_q              <= 3'd0;
      oc_size_q        <= '0;
      row_q            <= 3'd0;
      oc_q             <= '0;
      transfer_start_q <= 1'b0;
      write_en_q       <= 1'b0;
      add1_q           <= 1'b0;
      weight_valid_q   <= 1'b0;
      layer_finish_q   <= 1'b0;
      busy_q           <= 1'b0;
`ifdef WSCHED_DUAL_READ_EN
      total_q          <= '0;
      idx_q            <= '0;
      adv2_q           <= 1'b0;
      add2_q           <= 1'b0;
      port_sel_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      oc_size_q        <= oc_size_d;
      row_q            <= row_d;
      oc_q             <= oc_d;
      transfer_start_q <= transfer_start_d;
      write_en_q       <= write_en_d;
      add1_q           <= add1_d;
      weight_valid_q   <= weight_valid_d;
      layer_finish_q   <= layer_finish_d;
      busy_q           <= busy_d;
`ifdef WSCHED_DUAL_READ_EN
      total_q          <= total_d;
      idx_q            <= idx_d;
      adv2_q           <= adv2_d;
      add2_q           <= add2_d;
      port_sel_q       <= port_sel_d;
`endif
    end
  end

  assign bus.transfer_start    = transfer_start_q;
  assign bus.write_en          = write_en_q;
  assign bus.bram_control_add1 = add1_q;
  assign bus.weight_valid      = weight_valid_q;
  assign bus.cur_row           = row_q;
  assign bus.cur_oc            = oc_q;
  assign bus.layer_finish      = layer_finish_q;
  assign bus.busy              = busy_q;
`ifdef WSCHED_DUAL_READ_EN
  assign bus.bram_control_add2 = add2_q;
  assign bus.port_sel          = port_sel_q;
`else
  assign bus.bram_control_add2 = 1'b0;
  assign bus.port_sel          = 1'b0;
`endif

endmodule

// File: tb/tb_weight_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_weight_read_scheduler
// Self-checking bench for weight_read_scheduler. Expected (port_sel,row,oc)
// tuples are queued when a layer command is driven and compared at each
// weight handshake. A small BRAM model answers every read request
// (read transfer_start, add1, add2) with a valid pulse two cycles later.
// -----------------------------------------------------------------------------
module tb_weight_read_scheduler;

  localparam int OCW = 12;
  localparam int KSW = 5;
`ifdef WSCHED_DUAL_READ_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  weight_read_scheduler_if #(.OC_WIDTH(OCW), .KS_WIDTH(KSW)) bus ();

  weight_read_scheduler #(.OC_WIDTH(OCW), .KS_WIDTH(KSW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_ts, n_we, n_add1, n_add2, n_fin, n_wv, n_hs;
  int exp_total, exp_add1, exp_add2;
  logic [15:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // BRAM read model: valid two cycles after a read request.
  logic [1:0] bram_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bram_pipe <= 2'b00;
    else bram_pipe <= {bram_pipe[0],
                       (bus.transfer_start && !bus.write_en) ||
                        bus.bram_control_add1 || bus.bram_control_add2};
  end
  assign bus.weight_from_bram_valid = bram_pipe[1];

  // Monitor: pulse counters and scoreboard comparison at each handshake.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.transfer_start)    n_ts++;
        if (bus.write_en)          n_we++;
        if (bus.bram_control_add1) n_add1++;
        if (bus.bram_control_add2) n_add2++;
        if (bus.layer_finish)      n_fin++;
        if (bus.weight_valid)      n_wv++;
        if (bus.weight_valid && bus.weight_ready) begin
          n_hs++;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("row_oc", 32'({bus.port_sel, bus.cur_row, bus.cur_oc}), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    n_ts = 0; n_we = 0; n_add1 = 0; n_add2 = 0; n_fin = 0; n_wv = 0; n_hs = 0;
  endtask

  // Reference sequence of rows for a K x OC layer, plus expected add pulses.
  task automatic push_layer(input int k, input int oc);
    logic ps;
    ps = 1'b0;
    exp_total = k * oc;
    exp_add1 = 0;
    exp_add2 = 0;
    for (int i = 0; i < exp_total; i++) begin
      sb.push_back({ps, 3'(i % k), 12'(i / k)});
      if (i != exp_total - 1) begin
        if (DUAL && !ps && (exp_total - i - 1 >= 2)) begin
          ps = 1'b1;
        end else begin
          if (ps) exp_add2++;
          else exp_add1++;
          ps = 1'b0;
        end
      end
    end
  endtask

  // One-cycle command; config is scrambled afterwards to prove it was latched.
  task automatic start_layer(input logic [4:0] ks, input int oc, input bit load);
    @(negedge clk);
    bus.layer_start         = 1'b1;
    bus.kernel_size         = ks;
    bus.output_channel_size = 12'(oc);
    bus.load_weights        = load;
    @(negedge clk);
    bus.layer_start         = 1'b0;
    bus.kernel_size         = 5'b00011;
    bus.output_channel_size = 12'hfff;
    bus.load_weights        = 1'b1;
  endtask

  task automatic wait_finish(input int budget, output int lat);
    lat = 1;
    while (!bus.layer_finish && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check("finish_seen", 32'(bus.layer_finish), 32'd1);
    check("busy_at_finish", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #1;
    check("busy_after_finish", 32'(bus.busy), 32'd0);
    check("finish_one_cycle", 32'(bus.layer_finish), 32'd0);
  endtask

  task automatic post_checks(input int exp_ts);
    check("handshakes", 32'(n_hs), 32'(exp_total));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("finish_count", 32'(n_fin), 32'd1);
    check("add1_count", 32'(n_add1), 32'(exp_add1));
    check("add2_count", 32'(n_add2), 32'(exp_add2));
    check("ts_count", 32'(n_ts), 32'(exp_ts));
  endtask

  task automatic run_layer(input logic [4:0] ks, input int k, input int oc);
    int lat;
    clear_counts();
    push_layer(k, oc);
    start_layer(ks, oc, 1'b0);
    wait_finish(400, lat);
    post_checks(1);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_wv"}, 32'(bus.weight_valid), 32'd0);
    check({tag, "_ts"}, 32'(bus.transfer_start), 32'd0);
    check({tag, "_we"}, 32'(bus.write_en), 32'd0);
    check({tag, "_fin"}, 32'(bus.layer_finish), 32'd0);
    check({tag, "_add"}, 32'({bus.bram_control_add1, bus.bram_control_add2}), 32'd0);
    check({tag, "_ps"}, 32'(bus.port_sel), 32'd0);
    check({tag, "_row_oc"}, 32'({bus.cur_row, bus.cur_oc}), 32'd0);
  endtask

  initial begin
    int lat;
    int budget;
    logic [2:0]  row0;
    logic [11:0] oc0;
    int adds0;

    bus.layer_start = 1'b0;
    bus.load_weights = 1'b0;
    bus.kernel_size = 5'b00001;
    bus.output_channel_size = 12'd0;
    bus.write_weight_finish = 1'b0;
    bus.weight_ready = 1'b1;
    clear_counts();

    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // K=3, OC=2, no preload, consumer always ready.
    run_layer(5'b00100, 3, 2);

    // Preload: K=1, OC=4, write finish 10 cycles after the load starts.
    clear_counts();
    push_layer(1, 4);
    start_layer(5'b00001, 4, 1'b1);
    check("ld_start_ts", 32'(bus.transfer_start), 32'd1);
    check("ld_start_we", 32'(bus.write_en), 32'd1);
    repeat (10) @(negedge clk);
    bus.write_weight_finish = 1'b1;
    @(negedge clk);
    bus.write_weight_finish = 1'b0;
    check("ld_gap_we", 32'(bus.write_en), 32'd0);
    check("ld_gap_ts", 32'(bus.transfer_start), 32'd0);
    check("ld_gap_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("rd_start_ts", 32'(bus.transfer_start), 32'd1);
    check("rd_start_we", 32'(bus.write_en), 32'd0);
    wait_finish(400, lat);
    post_checks(2);
    check("we_cycles", 32'(n_we), 32'd11);

    // OC=0: straight to finish, nothing issued.
    clear_counts();
    push_layer(2, 0);
    start_layer(5'b00010, 0, 1'b0);
    wait_finish(10, lat);
    check("oc0_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
    post_checks(0);
    check("oc0_no_wv", 32'(n_wv), 32'd0);

    // Consumer stall for 7 cycles with an ignored layer_start in the middle.
    bus.weight_ready = 1'b0;
    clear_counts();
    push_layer(2, 2);
    start_layer(5'b00010, 2, 1'b0);
    budget = 0;
    while (!bus.weight_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    #1;
    check("stall_valid_seen", 32'(bus.weight_valid), 32'd1);
    row0 = bus.cur_row;
    oc0 = bus.cur_oc;
    check("stall_first_row_oc", 32'({row0, oc0}), 32'd0);
    adds0 = n_add1 + n_add2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.layer_start = 1'b1;
        bus.output_channel_size = 12'd0;
        bus.kernel_size = 5'b00001;
      end
      if (i == 3) bus.layer_start = 1'b0;
      #1;
      check("stall_wv", 32'(bus.weight_valid), 32'd1);
      check("stall_row_oc", 32'({bus.cur_row, bus.cur_oc}), 32'({row0, oc0}));
    end
    check("stall_no_add", 32'(n_add1 + n_add2), 32'(adds0));
    @(posedge clk);
    #1;
    bus.weight_ready = 1'b1;
    wait_finish(400, lat);
    post_checks(1);

    // Async reset while loading, then a clean layer from row 0 / oc 0.
    clear_counts();
    start_layer(5'b00010, 1, 1'b1);
    budget = 0;
    while (!bus.write_en && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_no_finish", 32'(n_fin), 32'd0);
    run_layer(5'b00010, 2, 2);

`ifdef WSCHED_DUAL_READ_EN
    // Dual read: K=5, OC=1 gives port_sel 0,1,0,1,0 and two add2 pulses.
    run_layer(5'b10000, 5, 1);
    check("dual_add2", 32'(n_add2), 32'd2);
    check("dual_add1", 32'(n_add1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
